// File: rtl/init_multi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : init_multi
// Brief    : Multi-channel S-array initialiser. Writes DEPTH words of a
//            selectable fill pattern to all enabled channels in one pass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module init_multi #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_value,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic [NUM_CH-1:0] wren,
  output logic              done
);

  localparam int c_PW = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam logic [ADDR_W-1:0] c_LAST_A = ADDR_W'(DEPTH - 1);
  localparam logic [c_PW-1:0]   c_LAST_P = c_PW'(DEPTH - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_FILL = 1'b1;

  logic [0:0]        r_state, w_state_nxt;
  logic [1:0]        r_mode, w_mode_nxt;
  logic [DATA_W-1:0] r_fill, w_fill_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic              w_rdy_nxt, w_done_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wrdata_nxt;
  logic [NUM_CH-1:0] w_wren_nxt;
  logic              w_accept, w_last;

  // Pattern is formed at the wider of address/data width, then truncated.
  function automatic logic [DATA_W-1:0] f_pattern(input logic [1:0]        m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] fv);
    logic [c_PW-1:0] v_a;
    logic [c_PW-1:0] v_r;
    v_a = c_PW'(a);
    case (m)
      2'b00:   v_r = v_a;
      2'b01:   v_r = c_LAST_P - v_a;
      2'b10:   v_r = c_PW'(fv);
      default: v_r = v_a ^ c_PW'(fv);
    endcase
    return v_r[DATA_W-1:0];
  endfunction

  assign w_accept = (r_state == c_IDLE) && rdy && en && (|ch_mask);
  assign w_last   = (addr == c_LAST_A);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_mode  <= '0;
      r_fill  <= '0;
      r_mask  <= '0;
      rdy     <= 1'b0;
      addr    <= '0;
      wrdata  <= '0;
      wren    <= '0;
      done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_fill  <= w_fill_nxt;
      r_mask  <= w_mask_nxt;
      rdy     <= w_rdy_nxt;
      addr    <= w_addr_nxt;
      wrdata  <= w_wrdata_nxt;
      wren    <= w_wren_nxt;
      done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_accept) w_state_nxt = c_FILL;
      c_FILL:  if (abort || w_last) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    w_mode_nxt   = r_mode;
    w_fill_nxt   = r_fill;
    w_mask_nxt   = r_mask;
    w_rdy_nxt    = rdy;
    w_addr_nxt   = addr;
    w_wrdata_nxt = wrdata;
    w_wren_nxt   = wren;
    w_done_nxt   = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_rdy_nxt  = 1'b1;
        w_wren_nxt = '0;
        if (w_accept) begin
          w_mode_nxt   = mode;
          w_fill_nxt   = fill_value;
          w_mask_nxt   = ch_mask;
          w_rdy_nxt    = 1'b0;
          w_addr_nxt   = '0;
          w_wren_nxt   = ch_mask;
          w_wrdata_nxt = f_pattern(mode, '0, fill_value);
        end
      end
      c_FILL: begin
        // The write on the bus during an abort cycle is still committed.
        if (abort) begin
          w_wren_nxt = '0;
          w_rdy_nxt  = 1'b1;
        end else if (w_last) begin
          w_wren_nxt = '0;
          w_rdy_nxt  = 1'b1;
          w_done_nxt = 1'b1;
        end else begin
          w_addr_nxt   = addr + ADDR_W'(1);
          w_wrdata_nxt = f_pattern(r_mode, addr + ADDR_W'(1), r_fill);
        end
      end
      default: begin
        w_wren_nxt = '0;
        w_rdy_nxt  = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_init_multi.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_init_multi
// Brief    : Randomised bench for init_multi against a pattern/sequence model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_init_multi;

  logic       clk = 1'b0;
  logic       rst_n, en, abort;
  logic [1:0] mode;
  logic [7:0] fill_value;
  logic [3:0] ch_mask;
  logic       rdy, done;
  logic [7:0] addr, wrdata;
  logic [3:0] wren;

  logic       s_en, s_abort;
  logic [1:0] s_mode;
  logic [7:0] s_fill;
  logic [0:0] s_mask;
  logic       s_rdy, s_done;
  logic [3:0] s_addr;
  logic [7:0] s_wrdata;
  logic [0:0] s_wren;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  init_multi dut (
    .clk(clk), .rst_n(rst_n), .en(en), .abort(abort), .mode(mode),
    .fill_value(fill_value), .ch_mask(ch_mask), .rdy(rdy), .addr(addr),
    .wrdata(wrdata), .wren(wren), .done(done)
  );

  init_multi #(.ADDR_W(4), .DATA_W(8), .DEPTH(10), .NUM_CH(1)) dut_small (
    .clk(clk), .rst_n(rst_n), .en(s_en), .abort(s_abort), .mode(s_mode),
    .fill_value(s_fill), .ch_mask(s_mask), .rdy(s_rdy), .addr(s_addr),
    .wrdata(s_wrdata), .wren(s_wren), .done(s_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_pat(int m, int a, int fv, int depth);
    int r;
    case (m)
      0:       r = a;
      1:       r = depth - 1 - a;
      2:       r = fv;
      default: r = a ^ fv;
    endcase
    return r & 'hFF;
  endfunction

  // stop_kind: 0 = abort at stop_at, 1 = reset at stop_at; stop_at < 0 runs to completion
  task automatic run_pass(input int m, input int fv, input int msk,
                          input int stop_at, input int stop_kind, input bit hold_en);
    chk("pre_rdy", 32'(rdy), 1);
    mode = 2'(m); fill_value = 8'(fv); ch_mask = 4'(msk); en = 1'b1;
    tick;
    if (!hold_en) en = 1'b0;
    for (int k = 0; k < 256; k++) begin
      chk("wren", 32'(wren), 32'(msk));
      chk("addr", 32'(addr), 32'(k));
      chk("wrdata", 32'(wrdata), 32'(exp_pat(m, k, fv, 256)));
      chk("rdy_busy", 32'(rdy), 0);
      chk("done_busy", 32'(done), 0);
      mode = 2'($urandom); fill_value = 8'($urandom); ch_mask = 4'($urandom);
      if (k == stop_at) begin
        if (stop_kind == 0) begin
          abort = 1'b1;
          tick;
          abort = 1'b0;
          chk("abort_wren", 32'(wren), 0);
          chk("abort_rdy", 32'(rdy), 1);
          chk("abort_done", 32'(done), 0);
          chk("abort_addr_hold", 32'(addr), 32'(k));
          tick;
          chk("abort_nodone", 32'(done), 0);
          chk("abort_idle_wren", 32'(wren), 0);
        end else begin
          rst_n = 1'b0;
          tick;
          rst_n = 1'b1;
          chk("rst_wren", 32'(wren), 0);
          chk("rst_rdy", 32'(rdy), 0);
          chk("rst_done", 32'(done), 0);
          tick;
          chk("rst_release_rdy", 32'(rdy), 1);
          chk("rst_release_done", 32'(done), 0);
        end
        return;
      end
      tick;
    end
    chk("end_done", 32'(done), 1);
    chk("end_rdy", 32'(rdy), 1);
    chk("end_wren", 32'(wren), 0);
    chk("end_addr_hold", 32'(addr), 255);
    if (!hold_en) begin
      for (int i = 0; i < 3; i++) begin
        tick;
        chk("post_done", 32'(done), 0);
        chk("post_wren", 32'(wren), 0);
        chk("post_rdy", 32'(rdy), 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; abort = 1'b0; mode = '0; fill_value = '0; ch_mask = '0;
    s_en = 1'b0; s_abort = 1'b0; s_mode = '0; s_fill = '0; s_mask = '0;
    repeat (3) tick;
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_wren", 32'(wren), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_wrdata", 32'(wrdata), 0);
    chk("rst_done", 32'(done), 0);
    rst_n = 1'b1;
    tick;
    chk("rdy_after_rst", 32'(rdy), 1);

    run_pass(0, 0, 15, -1, 0, 1'b0);
    run_pass(1, 'hA5, 5, -1, 0, 1'b0);
    run_pass(3, 'hA5, 5, -1, 0, 1'b0);
    run_pass(0, 0, 15, 100, 0, 1'b0);
    run_pass(2, 'h11, 3, -1, 0, 1'b0);
    run_pass(3, 'h5A, 15, 50, 1, 1'b0);
    run_pass(0, 0, 15, -1, 0, 1'b0);

    // zero mask ignored
    mode = 2'b00; ch_mask = 4'b0000; en = 1'b1;
    tick;
    en = 1'b0;
    chk("zmask_rdy", 32'(rdy), 1);
    chk("zmask_wren", 32'(wren), 0);
    // abort in idle ignored
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("idle_abort_rdy", 32'(rdy), 1);
    chk("idle_abort_wren", 32'(wren), 0);
    // en beats abort in idle, then abort mid-pass
    ch_mask = 4'b0010; en = 1'b1; abort = 1'b1;
    tick;
    en = 1'b0; abort = 1'b0;
    chk("en_wins_wren", 32'(wren), 2);
    chk("en_wins_addr", 32'(addr), 0);
    chk("en_wins_rdy", 32'(rdy), 0);
    tick;
    chk("en_wins_addr1", 32'(addr), 1);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("early_abort_wren", 32'(wren), 0);
    chk("early_abort_done", 32'(done), 0);
    tick;

    // back-to-back with en held
    run_pass(0, 0, 15, -1, 0, 1'b1);
    run_pass(1, 0, 9, -1, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      int m, fv, msk, stop, kind;
      m    = $urandom_range(0, 3);
      fv   = $urandom_range(0, 255);
      msk  = $urandom_range(1, 15);
      stop = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 255) : -1;
      kind = $urandom_range(0, 1);
      run_pass(m, fv, msk, stop, kind, 1'b0);
    end

    // small instance: constant fill over 10 words
    chk("small_rdy", 32'(s_rdy), 1);
    s_mode = 2'b10; s_fill = 8'h3C; s_mask = 1'b1; s_en = 1'b1;
    tick;
    s_en = 1'b0; s_mode = 2'b00; s_fill = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      chk("small_wren", 32'(s_wren), 1);
      chk("small_addr", 32'(s_addr), 32'(k));
      chk("small_wrdata", 32'(s_wrdata), 'h3C);
      chk("small_done_busy", 32'(s_done), 0);
      tick;
    end
    chk("small_done", 32'(s_done), 1);
    chk("small_end_wren", 32'(s_wren), 0);
    chk("small_end_rdy", 32'(s_rdy), 1);
    tick;
    chk("small_post_done", 32'(s_done), 0);
    chk("small_post_wren", 32'(s_wren), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/init_multi.md
Name: init_multi

Overview:
- Parametrised successor of the S-array initialiser for the parallel cracking datapath.
- Fills DEPTH words of up to NUM_CH per-core S memories in one pass, writing one word per cycle to all enabled channels at once.
- Fill pattern is selectable: identity, reverse, constant or XOR-identity.
- Uses the same en/rdy request handshake as the single-core initialiser, plus abort and a done pulse.

Parameters:
ADDR_W, 8, address width.
DATA_W, 8, write-data width; pattern values are truncated or zero-extended to DATA_W.
DEPTH, 256, words written per pass; legal range 1 <= DEPTH <= 2**ADDR_W.
NUM_CH, 4, number of memory channels (cracking cores).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
en  in  1  start request; accepted only when rdy=1.
abort  in  1  terminate the current pass.
mode  in  2  fill pattern, sampled at accept: 00 identity, 01 reverse, 10 constant, 11 XOR.
fill_value  in  DATA_W  operand for modes 10/11, sampled at accept.
ch_mask  in  NUM_CH  channels to write, sampled at accept.
rdy  out  1  idle and able to accept en.
addr  out  ADDR_W  shared write address to all channels.
wrdata  out  DATA_W  shared write data to all channels.
wren  out  NUM_CH  per-channel write enable.
done  out  1  one-cycle pulse when a pass completes normally.

Behaviour:
- Outputs: all outputs are registered.
- Reset: when rst_n=0 at a posedge, state becomes IDLE and rdy, wren, addr, wrdata and done all go to 0. This applies mid-pass: writing stops immediately and there is no done pulse.
- rdy after reset: rdy rises at the first posedge where rst_n=1.
- States: IDLE and FILL.
- Accept: in IDLE, if rdy=1 and en=1 at a posedge:
  - latch mode, fill_value and ch_mask;
  - enter FILL; rdy=0;
  - addr=0; wren=latched mask; wrdata=pattern(0).
  The first write is therefore visible to memory at the next posedge.
- Zero mask: en with ch_mask=0 is ignored; the block stays in IDLE with rdy=1.
- en while rdy=0 is ignored.
- FILL, per cycle: each posedge with addr < DEPTH-1 increments addr by 1 and updates wrdata; wren stays at the latched mask.
- Write count: exactly DEPTH consecutive write cycles, addresses 0..DEPTH-1 in order, with no gaps.
- Completion: at the posedge ending the write cycle of addr=DEPTH-1:
  - wren=0, rdy=1, done=1 for one cycle;
  - state returns to IDLE; addr and wrdata hold their last values.
- Back-to-back passes: a new en may be accepted in the cycle rdy is high, so the next pass's first write follows the done cycle.
- Pattern(a), computed at full width then resized to DATA_W:
  - 00 identity: a;
  - 01 reverse: DEPTH-1-a;
  - 10 constant: fill_value;
  - 11 XOR: a ^ fill_value.
- Abort: abort=1 at a posedge during FILL:
  - wren=0 and rdy=1 from that edge; state returns to IDLE;
  - done stays 0;
  - the write presented in that cycle is the last one committed.
  abort in IDLE has no effect. If abort and en are both 1 in IDLE, en wins.
- Simultaneous events: rst_n has priority over abort, which has priority over normal sequencing.
- Post-completion: wren remains 0 in IDLE indefinitely.
- Input stability: mode, fill_value and ch_mask may change freely during FILL without effect.
- Degenerate depth: DEPTH=1 gives one write cycle, then done.

Test Plan:
1. Default params, reset 3 cycles, wait rdy, en pulse with mode=00 and ch_mask=4'b1111 -> 256 writes, addr==wrdata==count 0..255 and wren=4'b1111 on each; then rdy=1 and done=1 for exactly one cycle; wren=0 for the next 3 cycles.
2. mode=01 and mode=11 with fill_value=8'hA5, ch_mask=4'b0101 -> wrdata=255-addr and addr^8'hA5 respectively; wren=4'b0101 throughout; channels 1 and 3 never written.
3. abort asserted while addr=100 -> last committed write is at addr 100; wren=0 and rdy=1 at the next edge; done never pulses; a new en then restarts cleanly from addr 0.
4. rst_n=0 while addr=50 -> at the next edge wren=0, rdy=0, done=0; after release rdy=1, and a fresh pass produces 256 writes.
5. Handshake corners:
   - en with ch_mask=0 -> ignored, rdy stays 1;
   - en held high through a pass and after done -> pass 1 writes 0..255 (256 cycles), pass 2 accepted in the rdy cycle, so addr 0 of pass 2 arrives 2 cycles after addr 255;
   - mode changed mid-pass -> no effect on wrdata.
6. Parameter sweep ADDR_W=4, DATA_W=8, DEPTH=10, NUM_CH=1, mode=10 with fill_value=8'h3C -> 10 writes at addr 0..9, all with wrdata=8'h3C, then done.
